// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage with prefetch FIFO and flush/stall handling
//
// Purpose: owns the fetch PC, issues in-order word requests to instruction
// memory (req/ack + rvalid), buffers responses in a small prefetch FIFO and
// presents one {pc, inst, valid} per cycle to the IF/ID register.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   stall_i        hold outputs, pop nothing
//   flush_i        redirect fetch to new_pc_i (highest priority)
//   new_pc_i       redirect target, word aligned
//   imem_req_o     request valid
//   imem_addr_o    request address (fetch PC)
//   imem_ack_i     request accepted this cycle
//   imem_rvalid_i  in-order response valid
//   imem_rdata_i   response instruction
//   pc_o           PC of the presented instruction
//   inst_o         presented instruction, 0 when not valid
//   inst_valid_o   pc_o/inst_o hold a real instruction
//   perf_bubble_o  saturating fetch-bubble counter (only with IF_FETCH_PERF_EN)
//
// Optional feature macro: IF_FETCH_PERF_EN

module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] perf_bubble_o,
`endif
    output logic        inst_valid_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_disc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_fifo_inst [FIFO_DEPTH];
    logic [31:0]   r_pc;
    logic [31:0]   r_inst;
    logic          r_valid;

    logic [SW-1:0] w_slots;
    logic [SW-1:0] w_tracked;
    logic [SW-1:0] w_flush_disc;
    logic          w_req;
    logic          w_acc;
    logic          w_rv_drop;
    logic          w_rv_live;
    logic          w_push;
    logic          w_pop;

    // Buffered plus in-flight words bound FIFO occupancy; tracked responses
    // (live plus to-be-dropped) bound what memory may still return.
    assign w_slots   = SW'(r_count) + SW'(r_outst);
    assign w_tracked = SW'(r_outst) + SW'(r_disc);

    // Gated by rst so the request is low while reset is held.
    assign w_req = rst && !flush_i && (w_slots < DEPTH_S) && (w_tracked < DEPTH_S);
    assign w_acc = w_req && imem_ack_i;

    // Stale responses from before a redirect are consumed first.
    assign w_rv_drop = imem_rvalid_i && (r_disc != '0);
    assign w_rv_live = imem_rvalid_i && (r_disc == '0) && (r_outst != '0);
    assign w_push    = w_rv_live && !flush_i;
    assign w_pop     = !flush_i && !stall_i && (r_count != '0);

    // Everything still owed by memory after this edge becomes stale on a flush.
    assign w_flush_disc = w_tracked + SW'(w_acc) - SW'(w_rv_live) - SW'(w_rv_drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_disc     <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (flush_i) begin
            r_fetch_pc <= new_pc_i;
            r_resp_pc  <= new_pc_i;
            r_outst    <= '0;
            r_disc     <= CW'(w_flush_disc);
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (w_acc) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wptr    <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_outst <= r_outst + CW'(w_acc) - CW'(w_push);
            r_disc  <= r_disc - CW'(w_rv_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_resp_pc;
            r_fifo_inst[r_wptr] <= imem_rdata_i;
        end
    end

    // Output register: no bypass, so a fresh push is poppable one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= '0;
            r_inst  <= '0;
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_inst  <= '0;
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            if (r_count != '0) begin
                r_pc    <= r_fifo_pc[r_rptr];
                r_inst  <= r_fifo_inst[r_rptr];
                r_valid <= 1'b1;
            end else begin
                r_inst  <= '0;
                r_valid <= 1'b0;
            end
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (!stall_i && !flush_i && (r_count == '0) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_bubble_o = r_perf;
`endif

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_fetch_pc;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid_i && (w_tracked == '0)));

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch with a queue-based reference model

module tb_if_fetch;

    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] XK  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_bubble_o;
`endif

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
`ifdef IF_FETCH_PERF_EN
        .perf_bubble_o(perf_bubble_o),
`endif
        .inst_valid_o (inst_valid_o)
    );

    // Reference model: each request carries its own address and a stale tag.
    logic [31:0] m_fetch;
    logic [31:0] m_infl_addr [$];
    bit          m_infl_stale[$];
    logic [31:0] m_fq_pc  [$];
    logic [31:0] m_fq_inst[$];
    logic [31:0] m_pc, m_inst, m_perf;
    logic        m_valid;

    logic [31:0] mem_q[$];

    int ack_pct, rv_pct, stall_pct, flush_pct;
    int force_flush;
    logic [31:0] force_pc;
    int n_checks = 0;
    int n_err = 0;
    logic [31:0] vpcs[$];
    logic [31:0] vinsts[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fetch = RPC;
        m_infl_addr.delete();
        m_infl_stale.delete();
        m_fq_pc.delete();
        m_fq_inst.delete();
        m_pc = '0;
        m_inst = '0;
        m_valid = 1'b0;
        m_perf = '0;
    endfunction

    function automatic bit model_req();
        int live = 0;
        foreach (m_infl_stale[i]) if (!m_infl_stale[i]) live++;
        return !flush_i && (m_fq_pc.size() + live < D) && (m_infl_addr.size() < D);
    endfunction

    function automatic void model_edge(input bit req);
        bit acc = req && imem_ack_i;
        bit fempty = (m_fq_pc.size() == 0);
        logic [31:0] a;
        bit s;
        if (flush_i) begin
            m_valid = 1'b0;
            m_inst  = '0;
        end else if (!stall_i) begin
            if (!fempty) begin
                m_pc    = m_fq_pc.pop_front();
                m_inst  = m_fq_inst.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_inst  = '0;
            end
        end
        if (!stall_i && !flush_i && fempty && m_perf != 32'hFFFF_FFFF) m_perf++;
        if (imem_rvalid_i && m_infl_addr.size() > 0) begin
            a = m_infl_addr.pop_front();
            s = m_infl_stale.pop_front();
            if (!s && !flush_i) begin
                m_fq_pc.push_back(a);
                m_fq_inst.push_back(imem_rdata_i);
            end
        end
        if (acc) begin
            m_infl_addr.push_back(m_fetch);
            m_infl_stale.push_back(1'b0);
            m_fetch = m_fetch + 32'd4;
        end
        if (flush_i) begin
            m_fq_pc.delete();
            m_fq_inst.delete();
            foreach (m_infl_stale[i]) m_infl_stale[i] = 1'b1;
            m_fetch = new_pc_i;
        end
    endfunction

    // Entered and left at a falling edge.
    task automatic step();
        bit exp_req;
        bit env_acc;
        logic [31:0] env_addr;
        stall_i = ($urandom_range(99) < stall_pct);
        if (force_flush != 0) begin
            flush_i  = 1'b1;
            new_pc_i = force_pc;
        end else begin
            flush_i  = ($urandom_range(99) < flush_pct);
            new_pc_i = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        end
        imem_ack_i = ($urandom_range(99) < ack_pct);
        if (mem_q.size() > 0 && $urandom_range(99) < rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_q[0] ^ XK;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        exp_req = model_req();
        #1;
        chk("imem_req_o", {31'b0, imem_req_o}, {31'b0, exp_req});
        chk("imem_addr_o", imem_addr_o, m_fetch);
        env_acc  = imem_req_o && imem_ack_i;
        env_addr = imem_addr_o;
        @(posedge clk);
        if (imem_rvalid_i) void'(mem_q.pop_front());
        if (env_acc) mem_q.push_back(env_addr);
        model_edge(exp_req);
        #1;
        chk("inst_valid_o", {31'b0, inst_valid_o}, {31'b0, m_valid});
        chk("pc_o", pc_o, m_pc);
        chk("inst_o", inst_o, m_inst);
`ifdef IF_FETCH_PERF_EN
        chk("perf_bubble_o", perf_bubble_o, m_perf);
`endif
        if (inst_valid_o) begin
            vpcs.push_back(pc_o);
            vinsts.push_back(inst_o);
        end
        @(negedge clk);
    endtask

    // Entered at a falling edge; asserts reset between edges, left at a falling edge with reset released.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        imem_ack_i = 1'b0;
        imem_rvalid_i = 1'b0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, RPC);
`ifdef IF_FETCH_PERF_EN
        chk("rst_perf", perf_bubble_o, 32'd0);
`endif
        mem_q.delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int first_valid;
        logic [31:0] saved_addr, saved_pc, saved_inst;
        force_flush = 0;
        force_pc = '0;
        @(negedge clk);
        do_reset();

        // Always-ack memory answering one cycle later.
        ack_pct = 100; rv_pct = 100; stall_pct = 0; flush_pct = 0;
        #1;
        chk("first_req", {31'b0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        #1;
        @(negedge clk);
        // The extra cycle above was idle with ack low; keep the model in step.
        model_edge(1'b0);
        vpcs.delete(); vinsts.delete();
        first_valid = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (first_valid == 0 && vpcs.size() > 0) first_valid = k;
        end
        chk("first_valid_edge", first_valid, 32'd3);
        chk("seq_pc0", vpcs[0], 32'h0);
        chk("seq_pc1", vpcs[1], 32'h4);
        chk("seq_pc2", vpcs[2], 32'h8);
        chk("seq_inst1", vinsts[1], 32'h4 ^ XK);

        // Memory refuses requests.
        saved_addr = imem_addr_o;
        ack_pct = 0;
        for (int k = 0; k < 5; k++) step();
        chk("hold_addr", imem_addr_o, saved_addr);
        chk("hold_drained", {31'b0, inst_valid_o}, 32'd0);

        // Stall mid-stream.
        ack_pct = 100;
        for (int k = 0; k < 3; k++) step();
        saved_pc = pc_o;
        saved_inst = inst_o;
        stall_pct = 100;
        for (int k = 0; k < 4; k++) step();
        chk("stall_pc", pc_o, saved_pc);
        chk("stall_inst", inst_o, saved_inst);
        chk("stall_req_low", {31'b0, imem_req_o}, 32'd0);
        stall_pct = 0;
        for (int k = 0; k < 8; k++) step();

        // Flush with two requests outstanding and a response in the flush cycle.
        do_reset();
        rv_pct = 0;
        for (int k = 0; k < 3; k++) step();
        rv_pct = 100;
        force_flush = 1;
        force_pc = 32'h100;
        step();
        force_flush = 0;
        vpcs.delete(); vinsts.delete();
        for (int k = 0; k < 10; k++) step();
        chk("flush_pc0", vpcs[0], 32'h100);
        chk("flush_pc1", vpcs[1], 32'h104);

        // Randomized traffic with a mid-stream reset.
        ack_pct = 70; rv_pct = 60; stall_pct = 20; flush_pct = 5;
        for (int k = 0; k < 4000; k++) begin
            if (k == 2000) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
